mul_pipe_bank: RTL and testbench

//  Parametrised elastic register chain for the multiplier pipe (MUL1..MULn).

---
 rtl/mul_pipe_bank_pkg.sv | 29 ++
 rtl/mul_pipe_stage.sv | 64 ++++++
 rtl/mul_pipe_bank.sv | 107 ++++++++++
 tb/tb_mul_pipe_bank.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pipe_bank_pkg.sv
// Shared widths and helpers for the multiplier-pipe register chain.
// Default widths mirror the core's DATA_SIZE / ROB_WIDTH globals.
package mul_pipe_bank_pkg;

  localparam int DATA_SIZE  = 32;
  localparam int ROB_WIDTH  = 5;
  localparam int MAX_STAGES = 8;
  localparam int CNT_W      = $clog2(MAX_STAGES + 1);

  // Count of set bits in a (zero-padded) stage valid vector.
  function automatic logic [CNT_W-1:0] popcount_stages(input logic [MAX_STAGES-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = {CNT_W{1'b0}};
    for (int i = 0; i < MAX_STAGES; i++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  // ROB-tag kill comparator.
  function automatic logic tag_kill_hit(
    input logic                 kill_en,
    input logic [ROB_WIDTH-1:0] entry_tag,
    input logic [ROB_WIDTH-1:0] kill_tag
  );
    return kill_en & (entry_tag == kill_tag);
  endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One stage of the multiplier pipe: valid bit plus instr/data/tag payload.
// Payload only loads for a live incoming entry, so bubbles never disturb it.
module mul_pipe_stage
  import mul_pipe_bank_pkg::*;
#(
  parameter int DATA_W = DATA_SIZE,
  parameter int TAG_W  = ROB_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_adv,
  input  logic              i_in_v,
  input  logic              i_kill_hit,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_v,
  output logic [DATA_W-1:0] o_instr,
  output logic [DATA_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_tag
);

  logic              r_v;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_data;
  logic [TAG_W-1:0]  r_tag;

  // Valid bit: flush wins, then advance, otherwise hold minus a tag kill.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v <= 1'b0;
    end else if (i_flush) begin
      r_v <= 1'b0;
    end else if (i_adv) begin
      r_v <= i_in_v;
    end else begin
      r_v <= r_v & ~i_kill_hit;
    end
  end

  // Payload registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr <= {DATA_W{1'b0}};
      r_data  <= {DATA_W{1'b0}};
      r_tag   <= {TAG_W{1'b0}};
    end else if (!i_flush && i_adv && i_in_v) begin
      r_instr <= i_instr;
      r_data  <= i_data;
      r_tag   <= i_tag;
    end else begin
      r_instr <= r_instr;
      r_data  <= r_data;
      r_tag   <= r_tag;
    end
  end

  assign o_v     = r_v;
  assign o_instr = r_instr;
  assign o_data  = r_data;
  assign o_tag   = r_tag;

endmodule

// File: rtl/mul_pipe_bank.sv
// Elastic STAGES-deep register chain for the multiplier pipe with
// valid/ready backpressure, bubble collapse, flush and single-tag kill.
module mul_pipe_bank
  import mul_pipe_bank_pkg::*;
#(
  parameter int DATA_W = DATA_SIZE,
  parameter int TAG_W  = ROB_WIDTH,
  parameter int STAGES = 4,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              kill_valid,
  input  logic [TAG_W-1:0]  kill_tag,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [OCC_W-1:0]  occupancy
);

  logic [STAGES-1:0] w_v;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_hit;
  logic [STAGES-1:0] w_stage_in_v;
  logic              w_in_hit;
  logic [DATA_W-1:0] w_instr     [STAGES];
  logic [DATA_W-1:0] w_data      [STAGES];
  logic [TAG_W-1:0]  w_tag       [STAGES];
  logic [DATA_W-1:0] w_src_instr [STAGES];
  logic [DATA_W-1:0] w_src_data  [STAGES];
  logic [TAG_W-1:0]  w_src_tag   [STAGES];

  // Advance chain, walked from the output end so a bubble anywhere
  // lets everything upstream of it move in the same cycle.
  always_comb begin
    logic w_carry;
    w_adv   = {STAGES{1'b0}};
    w_carry = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_carry  = ~w_v[k] | w_carry;
      w_adv[k] = w_carry;
    end
  end

  // Kill comparators against each stage's current tag and the incoming tag.
  always_comb begin
    w_hit = {STAGES{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      w_hit[k] = tag_kill_hit(kill_valid, w_tag[k], kill_tag);
    end
    w_in_hit = tag_kill_hit(kill_valid, in_tag, kill_tag);
  end

  assign in_ready  = w_adv[0] & ~flush;
  assign out_valid = w_v[STAGES-1] & ~flush & ~w_hit[STAGES-1];
  assign out_instr = w_instr[STAGES-1];
  assign out_data  = w_data[STAGES-1];
  assign out_tag   = w_tag[STAGES-1];

  // Registered-valid popcount.
  always_comb begin
    occupancy = OCC_W'(popcount_stages(MAX_STAGES'(w_v)));
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_stage_in_v[k] = in_valid & in_ready & ~w_in_hit;
      assign w_src_instr[k]  = in_instr;
      assign w_src_data[k]   = in_data;
      assign w_src_tag[k]    = in_tag;
    end else begin : g_body
      // A killed entry that moves arrives as a bubble in its destination.
      assign w_stage_in_v[k] = w_v[k-1] & ~w_hit[k-1];
      assign w_src_instr[k]  = w_instr[k-1];
      assign w_src_data[k]   = w_data[k-1];
      assign w_src_tag[k]    = w_tag[k-1];
    end

    mul_pipe_stage #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W)
    ) u_stage (
      .i_clk      (clk),
      .i_rst_n    (reset),
      .i_adv      (w_adv[k]),
      .i_in_v     (w_stage_in_v[k]),
      .i_kill_hit (w_hit[k]),
      .i_flush    (flush),
      .i_instr    (w_src_instr[k]),
      .i_data     (w_src_data[k]),
      .i_tag      (w_src_tag[k]),
      .o_v        (w_v[k]),
      .o_instr    (w_instr[k]),
      .o_data     (w_data[k]),
      .o_tag      (w_tag[k])
    );
  end

endmodule

// File: tb/tb_mul_pipe_bank.sv
// Self-checking bench for mul_pipe_bank: directed scenarios plus random
// traffic, all checked against a queue-of-entries reference model.
module tb_mul_pipe_bank;

  localparam int S  = 4;
  localparam int DW = 32;
  localparam int TW = 5;
  localparam int OW = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          flush, kill_valid, in_valid, in_ready, out_valid, out_ready;
  logic [TW-1:0] kill_tag, in_tag, out_tag;
  logic [DW-1:0] in_instr, in_data, out_instr, out_data;
  logic [OW-1:0] occupancy;

  mul_pipe_bank #(.DATA_W(DW), .TAG_W(TW), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .flush(flush), .kill_valid(kill_valid), .kill_tag(kill_tag),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_data(in_data),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_data(out_data), .out_tag(out_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] instr;
    logic [DW-1:0] data;
    int            pos;
  } ent_t;

  ent_t q[$];          // q[0] is the oldest entry, nearest the output
  int   n_cmp = 0;
  int   n_err = 0;
  logic          obs_ir, obs_ov;
  logic [TW-1:0] obs_tag;
  int            obs_occ;

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic set_in(input bit v, input int tag);
    in_valid = v;
    in_tag   = TW'(tag);
    in_instr = $urandom;
    in_data  = $urandom;
  endtask

  // One clock cycle: predict, compare, then advance the model at the edge.
  // Called at posedge+1 with inputs already driven.
  task automatic cycle();
    bit   mv[S];
    int   n;
    bit   exp_ir, exp_ov, in_hit;
    ent_t nq[$];
    ent_t e;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      if (q[i].pos == S - 1)                mv[i] = out_ready;
      else if (i == 0)                      mv[i] = 1'b1;
      else mv[i] = (q[i-1].pos != q[i].pos + 1) || mv[i-1];
    end
    exp_ir = !flush && (n == 0 || q[n-1].pos != 0 || mv[n-1]);
    exp_ov = n > 0 && q[0].pos == S - 1 && !flush && !(kill_valid && q[0].tag == kill_tag);
    in_hit = kill_valid && in_tag == kill_tag;
    #2;
    obs_ir  = in_ready;
    obs_ov  = out_valid;
    obs_tag = out_tag;
    obs_occ = int'(occupancy);
    check_eq("in_ready", 64'(in_ready), 64'(exp_ir));
    check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
    check_eq("occupancy", 64'(occupancy), 64'(n));
    if (exp_ov) begin
      check_eq("out_tag", 64'(out_tag), 64'(q[0].tag));
      check_eq("out_instr", 64'(out_instr), 64'(q[0].instr));
      check_eq("out_data", 64'(out_data), 64'(q[0].data));
    end
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      for (int i = 0; i < n; i++) begin
        e = q[i];
        if (mv[i]) e.pos++;
        if (e.pos == S) continue;
        if (kill_valid && e.tag == kill_tag) continue;
        nq.push_back(e);
      end
      if (in_valid && exp_ir && !in_hit) begin
        e.tag = in_tag; e.instr = in_instr; e.data = in_data; e.pos = 0;
        nq.push_back(e);
      end
      q = nq;
    end
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      set_in(1'b0, 0);
      cycle();
    end
  endtask

  task automatic do_flush();
    flush = 1'b1; set_in(1'b0, 0); cycle(); flush = 1'b0;
  endtask

  initial begin
    int first;
    logic [TW-1:0] seen[$];

    reset = 1'b0; flush = 1'b0; kill_valid = 1'b0; kill_tag = '0;
    out_ready = 1'b0; set_in(1'b0, 0);
    #12 reset = 1'b1;
    @(posedge clk); #1;

    // 1. asynchronous reset with three live stages
    for (int i = 0; i < 3; i++) begin set_in(1'b1, 40 + i); cycle(); end
    set_in(1'b0, 0);
    #1 reset = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_occupancy", 64'(occupancy), 64'd0);
    check_eq("rst_out_tag", 64'(out_tag), 64'd0);
    check_eq("rst_out_instr", 64'(out_instr), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    q.delete();
    @(posedge clk); #2 reset = 1'b1; #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 2. streaming tags 1..8 back to back
    out_ready = 1'b1; first = -1;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) set_in(1'b1, i + 1); else set_in(1'b0, 0);
      cycle();
      if (obs_ov) begin
        if (first < 0) first = i;
        seen.push_back(obs_tag);
      end
    end
    check_eq("stream_latency", 64'(first), 64'd4);
    check_eq("stream_count", 64'(seen.size()), 64'd8);
    for (int k = 0; k < seen.size(); k++) check_eq("stream_order", 64'(seen[k]), 64'(k + 1));

    // 3. backpressure, then a single drain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin set_in(1'b1, 10 + i); cycle(); end
    set_in(1'b1, 14); cycle();
    check_eq("bp_full_ready", 64'(obs_ir), 64'd0);
    check_eq("bp_full_occ", 64'(obs_occ), 64'd4);
    out_ready = 1'b1; set_in(1'b0, 0); cycle();
    check_eq("bp_drain_ready", 64'(obs_ir), 64'd1);
    out_ready = 1'b0; idle(1);
    check_eq("bp_after_occ", 64'(obs_occ), 64'd3);
    idle(2);
    check_eq("bp_frozen_tag", 64'(obs_tag), 64'd11);
    do_flush();

    // 4. bubble collapse behind a stalled head
    set_in(1'b1, 20); cycle();
    idle(2);
    set_in(1'b1, 21); cycle();
    idle(4);
    check_eq("bubble_occ", 64'(obs_occ), 64'd2);
    check_eq("bubble_head", 64'(obs_tag), 64'd20);
    set_in(1'b1, 22); cycle();
    set_in(1'b1, 23); cycle();
    set_in(1'b1, 24); cycle();
    check_eq("bubble_full", 64'(obs_ir), 64'd0);
    do_flush();

    // 5. flush with an input offered
    for (int i = 0; i < 3; i++) begin set_in(1'b1, 30 + i); cycle(); end
    flush = 1'b1; set_in(1'b1, 33); cycle();
    check_eq("flush_out_valid", 64'(obs_ov), 64'd0);
    check_eq("flush_in_ready", 64'(obs_ir), 64'd0);
    flush = 1'b0; idle(1);
    check_eq("flush_occ", 64'(obs_occ), 64'd0);

    // 6. kill tag 6 in flight and arriving
    for (int i = 0; i < 3; i++) begin set_in(1'b1, 5 + i); cycle(); end
    kill_valid = 1'b1; kill_tag = TW'(6); set_in(1'b1, 6); cycle();
    check_eq("kill_occ_before", 64'(obs_occ), 64'd3);
    kill_valid = 1'b0; out_ready = 1'b1;
    seen.delete();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 0); cycle();
      if (i == 0) check_eq("kill_occ_after", 64'(obs_occ), 64'd2);
      if (obs_ov) seen.push_back(obs_tag);
    end
    check_eq("kill_count", 64'(seen.size()), 64'd2);
    if (seen.size() == 2) begin
      check_eq("kill_first", 64'(seen[0]), 64'd5);
      check_eq("kill_second", 64'(seen[1]), 64'd7);
    end

    // random traffic
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 7));
      out_ready  = $urandom_range(0, 9) < 6;
      flush      = $urandom_range(0, 99) < 3;
      kill_valid = $urandom_range(0, 9) < 1;
      kill_tag   = TW'($urandom_range(0, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
